// File: rtl/sw_lock_pkg.sv
// Shared types and constants for the switch-code lock.
// The SW_CODE_LOCK_MASTER_EN master-code option lives in sw_code_lock.
package sw_lock_pkg;

  localparam int unsigned BYTE       = 4;
  localparam int unsigned MAX_DIGITS = 4;
  localparam int unsigned CODE_W     = BYTE * MAX_DIGITS;
  localparam int unsigned CNT_W      = 3;
  localparam int unsigned ERR_W      = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    OPEN  = 3'd2,
    FAIL  = 3'd3,
    LOCK  = 3'd4
  } state_t;

  // Counter width covering the longest of the three hold times (never below 1).
  function automatic int unsigned timer_width(input int unsigned a,
                                              input int unsigned b,
                                              input int unsigned c);
    int unsigned m;
    int unsigned w;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    w = $clog2(m);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/sw_lock_timer.sv
// Shared hold-time counter: counts up from zero to a terminal value, clear has priority.
module sw_lock_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] term,
  output logic         tc_c
);

  logic [W-1:0] count;

  // Holds at the terminal value; the owner's state change clears it.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en && !tc_c) begin
      count <= count + W'(1);
    end
  end

  assign tc_c = (count == term);

endmodule

// File: rtl/sw_code_lock.sv
// Code lock: checks the switch-entry code on confirm, drives unlock/fail/alarm, locks out after repeated misses.
// Define SW_CODE_LOCK_MASTER_EN to accept MASTER_CODE in IDLE or LOCK (jumps straight to OPEN).
module sw_code_lock
  import sw_lock_pkg::*;
#(
  parameter logic [CODE_W-1:0] PASSWORD    = 16'h1234,
  parameter int unsigned       DIGITS      = 4,
  parameter int unsigned       MAX_TRIES   = 3,
  parameter int unsigned       OPEN_CYCLES = 50_000_000,
  parameter int unsigned       FAIL_CYCLES = 25_000_000,
  parameter int unsigned       LOCK_CYCLES = 500_000_000
`ifdef SW_CODE_LOCK_MASTER_EN
  ,
  parameter logic [CODE_W-1:0] MASTER_CODE = 16'h9999
`endif
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [CODE_W-1:0] Code,
  input  logic [CNT_W-1:0]  Code_Bit,
  input  logic              Confirm,
  output logic              Clear_Req,
  output logic              Unlock,
  output logic              Fail,
  output logic              Alarm,
  output logic [ERR_W-1:0]  Err_Cnt,
  output logic [2:0]        State
);

  localparam int unsigned TW = timer_width(OPEN_CYCLES, FAIL_CYCLES, LOCK_CYCLES);

  state_t              state;
  state_t              state_nxt_c;
  logic                confirm_q;
  logic [CODE_W-1:0]   code_q;
  logic [CNT_W-1:0]    bits_q;
  logic                press_c;
  logic                match_c;
  logic                lock_hit_c;
  logic                master_hit_c;
  logic                timing_c;
  logic                tc_c;
  logic [TW-1:0]       term_c;

  assign press_c = Confirm & ~confirm_q;

  assign match_c = (bits_q == CNT_W'(DIGITS)) &&
                   (code_q[BYTE*DIGITS-1:0] == PASSWORD[BYTE*DIGITS-1:0]);

  // Compare in one extra bit so a saturated count cannot wrap the threshold test.
  assign lock_hit_c = ((5'(Err_Cnt) + 5'd1) >= 5'(MAX_TRIES));

`ifdef SW_CODE_LOCK_MASTER_EN
  assign master_hit_c = press_c && (Code == MASTER_CODE) &&
                        (Code_Bit == CNT_W'(MAX_DIGITS)) &&
                        ((state == IDLE) || (state == LOCK));
`else
  assign master_hit_c = 1'b0;
`endif

  assign timing_c = (state == OPEN) || (state == FAIL) || (state == LOCK);

  always_comb begin
    term_c = '0;
    case (state)
      OPEN:    term_c = TW'(OPEN_CYCLES - 1);
      FAIL:    term_c = TW'(FAIL_CYCLES - 1);
      LOCK:    term_c = TW'(LOCK_CYCLES - 1);
      default: term_c = '0;
    endcase
  end

  // Next-state decode; undefined encodings fall back to IDLE.
  always_comb begin
    state_nxt_c = state;
    case (state)
      IDLE: begin
        if (master_hit_c)  state_nxt_c = OPEN;
        else if (press_c)  state_nxt_c = CHECK;
      end
      CHECK: begin
        if (match_c)         state_nxt_c = OPEN;
        else if (lock_hit_c) state_nxt_c = LOCK;
        else                 state_nxt_c = FAIL;
      end
      OPEN: if (tc_c) state_nxt_c = IDLE;
      FAIL: if (tc_c) state_nxt_c = IDLE;
      LOCK: begin
        if (master_hit_c) state_nxt_c = OPEN;
        else if (tc_c)    state_nxt_c = IDLE;
      end
      default: state_nxt_c = IDLE;
    endcase
  end

  // Timer restarts from zero on every state entry.
  sw_lock_timer #(.W(TW)) u_timer (
    .clk  (CLK),
    .rst  (RST),
    .clr  (state_nxt_c != state),
    .en   (timing_c),
    .term (term_c),
    .tc_c (tc_c)
  );

  // State, captured entry and registered output decodes.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      confirm_q <= 1'b1;
      code_q    <= '0;
      bits_q    <= '0;
      Err_Cnt   <= '0;
      Clear_Req <= 1'b0;
      Unlock    <= 1'b0;
      Fail      <= 1'b0;
      Alarm     <= 1'b0;
    end else begin
      state     <= state_nxt_c;
      confirm_q <= Confirm;

      if ((state == IDLE) && press_c) begin
        code_q <= Code;
        bits_q <= Code_Bit;
      end

      if (master_hit_c) begin
        Err_Cnt <= '0;
      end else if (state == CHECK) begin
        if (match_c)                 Err_Cnt <= '0;
        else if (Err_Cnt != 4'hF)    Err_Cnt <= Err_Cnt + 4'd1;
      end else if ((state == LOCK) && (state_nxt_c == IDLE)) begin
        Err_Cnt <= '0;
      end

      Clear_Req <= (state_nxt_c == CHECK) || master_hit_c;
      Unlock    <= (state_nxt_c == OPEN);
      Fail      <= (state_nxt_c == FAIL);
      Alarm     <= (state_nxt_c == LOCK);
    end
  end

  assign State = 3'(state);

endmodule
